ws2812_frame_tx: RTL and testbench

- Parametrised WS2812/NeoPixel frame serializer; successor to the fixed 64-LED on/off driver in the pong top level.
- Pixel data (full colour, any LED count) is pulled from an external pixel store through a registered address / 1-cycle-latency data port.
- Streams one complete frame per request, then holds the line low for the latch/reset period.
- Supports an optional free-running auto-refresh mode; drives a single output pin (uo_out[0] in the top level).

---
 rtl/ws2812_frame_tx.sv | 163 ++++++++++++++++
 tb/tb_ws2812_frame_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame serializer: streams NUM_LEDS pixels from an external store, then latches.
// Optional per-channel brightness scaling when WS2812_BRIGHTNESS_EN is defined.
module ws2812_frame_tx #(
   parameter int NUM_LEDS   = 64,
   parameter int COLOR_BITS = 24,
   parameter int BIT_CYC    = 12,
   parameter int T0H_CYC    = 4,
   parameter int T1H_CYC    = 8,
   parameter int RESET_CYC  = 600,
   localparam int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  auto_refresh,
`ifdef WS2812_BRIGHTNESS_EN
   input  logic [7:0]            brightness,
`endif
   output logic [ADDR_W-1:0]     pix_addr,
   input  logic [COLOR_BITS-1:0] pix_data,
   output logic                  dout,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BCNT_W  = $clog2(COLOR_BITS + 1);

   localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0]  RESET_LAST = CNT_W'(RESET_CYC - 1);
   localparam logic [CNT_W-1:0]  T0H_LIM    = CNT_W'(T0H_CYC);
   localparam logic [CNT_W-1:0]  T1H_LIM    = CNT_W'(T1H_CYC);
   localparam logic [BCNT_W-1:0] BITS_LAST  = BCNT_W'(COLOR_BITS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_LEDS - 1);

   typedef enum logic [1:0] {IDLE, PREFETCH, SEND, LATCH} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_W-1:0]       pix_addr_reg, pix_addr_next;
   logic [COLOR_BITS-1:0]   shift_reg, shift_next;
   logic [BCNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
   logic [CNT_W-1:0]        cyc_cnt_reg, cyc_cnt_next;
   logic                    last_pix_reg, last_pix_next;
   logic                    dout_reg, dout_next;
   logic                    frame_done_reg, frame_done_next;
   logic                    auto_pend_reg, auto_pend_next;
   logic                    load;
   logic [COLOR_BITS-1:0]   load_word;
   logic [CNT_W-1:0]        high_lim;

`ifdef WS2812_BRIGHTNESS_EN
   // Each byte lane scaled by (brightness+1)/256, so 255 is exact identity.
   for (genvar gi = 0; gi < COLOR_BITS / 8; gi++) begin : g_scale
      logic [15:0] prod;
      assign prod = (16'(pix_data[gi*8 +: 8]) * 16'(brightness)) + 16'(pix_data[gi*8 +: 8]);
      assign load_word[gi*8 +: 8] = 8'(prod >> 8);
   end
`else
   assign load_word = pix_data;
`endif

   assign high_lim = shift_reg[COLOR_BITS-1] ? T1H_LIM : T0H_LIM;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         pix_addr_reg   <= '0;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         cyc_cnt_reg    <= '0;
         last_pix_reg   <= 1'b0;
         dout_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         auto_pend_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pix_addr_reg   <= pix_addr_next;
         shift_reg      <= shift_next;
         bit_cnt_reg    <= bit_cnt_next;
         cyc_cnt_reg    <= cyc_cnt_next;
         last_pix_reg   <= last_pix_next;
         dout_reg       <= dout_next;
         frame_done_reg <= frame_done_next;
         auto_pend_reg  <= auto_pend_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pix_addr_next   = pix_addr_reg;
      shift_next      = shift_reg;
      bit_cnt_next    = bit_cnt_reg;
      cyc_cnt_next    = cyc_cnt_reg;
      last_pix_next   = last_pix_reg;
      dout_next       = 1'b0;
      frame_done_next = 1'b0;
      auto_pend_next  = auto_pend_reg;
      load            = 1'b0;

      case (state_reg)
         IDLE: begin
            // auto_pend only lives for the single IDLE cycle after LATCH
            auto_pend_next = 1'b0;
            if (start || auto_pend_reg) begin
               pix_addr_next = '0;
               cyc_cnt_next  = '0;
               bit_cnt_next  = '0;
               state_next    = PREFETCH;
            end
         end
         PREFETCH: begin
            load       = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            dout_next = (cyc_cnt_reg < high_lim);
            if (cyc_cnt_reg == BIT_LAST) begin
               if (bit_cnt_reg == BITS_LAST) begin
                  if (last_pix_reg) begin
                     cyc_cnt_next = '0;
                     state_next   = LATCH;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  shift_next   = shift_reg << 1;
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  cyc_cnt_next = '0;
               end
            end else begin
               cyc_cnt_next = cyc_cnt_reg + 1'b1;
            end
         end
         LATCH: begin
            if (cyc_cnt_reg == RESET_LAST) begin
               frame_done_next = 1'b1;
               auto_pend_next  = auto_refresh;
               cyc_cnt_next    = '0;
               state_next      = IDLE;
            end else begin
               cyc_cnt_next = cyc_cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Advancing the address here fetches the next pixel while this one is sent.
      if (load) begin
         shift_next    = load_word;
         bit_cnt_next  = '0;
         cyc_cnt_next  = '0;
         last_pix_next = (pix_addr_reg == ADDR_LAST);
         pix_addr_next = (pix_addr_reg == ADDR_LAST) ? pix_addr_reg : pix_addr_reg + 1'b1;
      end
   end

   assign pix_addr   = pix_addr_reg;
   assign dout       = dout_reg;
   assign busy       = (state_reg != IDLE);
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Directed bench: default 64x24 instance (a) and a 2-LED, 8-bit, short-latch instance (b).
// With WS2812_BRIGHTNESS_EN defined, instance (a) also exercises brightness scaling.
module tb_ws2812_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   logic        rst_n_a, start_a, auto_a, dout_a, busy_a, fd_a;
   logic [5:0]  pix_addr_a;
   logic [23:0] pix_data_a;
`ifdef WS2812_BRIGHTNESS_EN
   logic [7:0]  brightness_a;
   logic [7:0]  brightness_b;
`endif

   logic        rst_n_b, start_b, auto_b, dout_b, busy_b, fd_b;
   logic [0:0]  pix_addr_b;
   logic [7:0]  pix_data_b;
   logic [7:0]  mem_b [0:1];
   assign pix_data_b = mem_b[pix_addr_b];

   ws2812_frame_tx dut_a (
      .clk(clk), .rst_n(rst_n_a), .start(start_a), .auto_refresh(auto_a),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness(brightness_a),
`endif
      .pix_addr(pix_addr_a), .pix_data(pix_data_a),
      .dout(dout_a), .busy(busy_a), .frame_done(fd_a)
   );

   ws2812_frame_tx #(.NUM_LEDS(2), .COLOR_BITS(8), .RESET_CYC(30)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .start(start_b), .auto_refresh(auto_b),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness(brightness_b),
`endif
      .pix_addr(pix_addr_b), .pix_data(pix_data_b),
      .dout(dout_b), .busy(busy_b), .frame_done(fd_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic dout_of(input bit sel);
      return sel ? dout_b : dout_a;
   endfunction

   function automatic logic fd_of(input bit sel);
      return sel ? fd_b : fd_a;
   endfunction

   // Low cycles before the next rising edge, then the high width.
   task automatic get_hi(input bit sel, output int lo, output int hi, output bit tmo);
      lo = 0; hi = 0; tmo = 1'b0;
      while (dout_of(sel) !== 1'b1) begin
         if (lo >= 2000) begin tmo = 1'b1; return; end
         tick(); lo++;
      end
      while (dout_of(sel) === 1'b1) begin
         if (hi >= 100) begin tmo = 1'b1; return; end
         tick(); hi++;
      end
   endtask

   task automatic capture(input bit sel, input int nbits, output logic [23:0] word,
                          output int bad, output int ones);
      int lo, hi, prev_hi;
      bit tmo;
      word = '0; bad = 0; ones = 0; prev_hi = 0;
      for (int i = 0; i < nbits; i++) begin
         get_hi(sel, lo, hi, tmo);
         if (tmo) begin bad += nbits - i; break; end
         if (hi == 8) begin word = {word[22:0], 1'b1}; ones++; end
         else if (hi == 4) word = {word[22:0], 1'b0};
         else bad++;
         if (i > 0 && lo + prev_hi != 12) bad++;
         prev_hi = hi;
      end
   endtask

   task automatic wait_fd(input bit sel, output int t, output int hi_seen);
      int n;
      n = 0; t = -1; hi_seen = 0;
      while (fd_of(sel) !== 1'b1 && n < 3000) begin
         tick(); n++;
         if (dout_of(sel) === 1'b1) hi_seen++;
      end
      if (fd_of(sel) === 1'b1) t = cyc_n;
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0; start_b = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [23:0] word;
      int bad, ones, t0, tfd, hi_seen, fd_cnt, fd_at, n;
      int fd_t [0:2];

      rst_n_a = 1'b0; rst_n_b = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      auto_a  = 1'b0; auto_b  = 1'b0;
      pix_data_a = 24'h000000;
      mem_b[0] = 8'hA5; mem_b[1] = 8'h01;
`ifdef WS2812_BRIGHTNESS_EN
      brightness_a = 8'hFF; brightness_b = 8'hFF;
`endif
      #1;
      chk("reset_dout", dout_a, 0);
      chk("reset_busy", busy_a, 0);
      chk("reset_frame_done", fd_a, 0);
      chk("reset_pix_addr", pix_addr_a, 0);
      repeat (3) tick();
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      tick();

      // Test 1: full default frame of black pixels
      pulse_start(1'b0);
      t0 = cyc_n;
      chk("t1_busy_next_cycle", busy_a, 1);
      chk("t1_pix_addr_prefetch", pix_addr_a, 0);
      capture(1'b0, 1536, word, bad, ones);
      $display("t1: 1536 bits captured, bad=%0d ones=%0d", bad, ones);
      chk("t1_bit_shape", bad, 0);
      chk("t1_all_zero_bits", ones, 0);
      wait_fd(1'b0, tfd, hi_seen);
      $display("t1: frame_done at +%0d cycles", tfd - t0);
      chk("t1_latch_low", hi_seen, 0);
      chk("t1_start_to_done", tfd - t0, 1 + 1536 * 12 + 600);
      tick();
      chk("t1_done_one_cycle", fd_a, 0);
      chk("t1_idle_after", busy_a, 0);

      // Test 2: two 8-bit pixels A5, 01
      pulse_start(1'b1);
      t0 = cyc_n;
      chk("t2_pix_addr_prefetch", pix_addr_b, 0);
      capture(1'b1, 8, word, bad, ones);
      $display("t2: pixel0 word=%02h bad=%0d", word[7:0], bad);
      chk("t2_pixel0", word, 24'h0000A5);
      chk("t2_pixel0_shape", bad, 0);
      chk("t2_pix_addr_advanced", pix_addr_b, 1);
      capture(1'b1, 8, word, bad, ones);
      $display("t2: pixel1 word=%02h bad=%0d", word[7:0], bad);
      chk("t2_pixel1", word, 24'h000001);
      chk("t2_pixel1_shape", bad, 0);
      chk("t2_pix_addr_held", pix_addr_b, 1);
      wait_fd(1'b1, tfd, hi_seen);
      chk("t2_start_to_done", tfd - t0, 1 + 2 * 8 * 12 + 30);
      tick();
      chk("t2_idle_after", busy_b, 0);

      // Test 3: start during SEND (edge 50) and LATCH (edge 205) is ignored
      pulse_start(1'b1);
      fd_cnt = 0; fd_at = -1;
      for (int i = 1; i <= 400; i++) begin
         start_b = (i == 50 || i == 205);
         tick();
         start_b = 1'b0;
         if (fd_b === 1'b1) begin
            fd_cnt++;
            if (fd_at < 0) fd_at = i;
         end
      end
      $display("t3: frame_done count=%0d first at %0d", fd_cnt, fd_at);
      chk("t3_one_frame_done", fd_cnt, 1);
      chk("t3_done_time", fd_at, 223);
      chk("t3_idle_persists", busy_b, 0);

      // Test 4: auto refresh, three back-to-back frames
      auto_b = 1'b1;
      pulse_start(1'b1);
      fd_cnt = 0;
      fd_t[0] = -1; fd_t[1] = -1; fd_t[2] = -1;
      for (int i = 1; i <= 690; i++) begin
         tick();
         if (fd_b === 1'b1) begin
            if (fd_cnt < 3) fd_t[fd_cnt] = i;
            fd_cnt++;
         end
      end
      $display("t4: frame_done count=%0d at %0d %0d %0d", fd_cnt, fd_t[0], fd_t[1], fd_t[2]);
      chk("t4_three_frames", fd_cnt, 3);
      chk("t4_done0", fd_t[0], 223);
      chk("t4_done1", fd_t[1], 447);
      chk("t4_done2", fd_t[2], 671);
      auto_b = 1'b0;
      repeat (250) tick();
      chk("t4_stops_without_auto", busy_b, 0);

      // Test 5: asynchronous reset while dout is high
      pulse_start(1'b1);
      n = 0;
      while (dout_b !== 1'b1 && n < 20) begin tick(); n++; end
      chk("t5_dout_high_before_reset", dout_b, 1);
      #2;
      rst_n_b = 1'b0;
      #1;
      chk("t5_async_dout", dout_b, 0);
      chk("t5_async_busy", busy_b, 0);
      chk("t5_async_pix_addr", pix_addr_b, 0);
      tick(); tick();
      rst_n_b = 1'b1;
      tick();
      pulse_start(1'b1);
      chk("t5_restart_pix_addr", pix_addr_b, 0);
      capture(1'b1, 16, word, bad, ones);
      $display("t5: restarted frame word=%04h bad=%0d", word[15:0], bad);
      chk("t5_clean_frame", word, 24'h00A501);
      chk("t5_clean_shape", bad, 0);
      wait_fd(1'b1, tfd, hi_seen);
      chk("t5_frame_done_seen", fd_b, 1);

      // Test 6: first pixel of a coloured frame on the 24-bit instance
      pix_data_a = 24'hFF8040;
`ifdef WS2812_BRIGHTNESS_EN
      brightness_a = 8'h7F;
      pulse_start(1'b0);
      capture(1'b0, 24, word, bad, ones);
      $display("t6: scaled word=%06h bad=%0d", word, bad);
      chk("t6_scaled_word", word, 24'h7F4020);
`else
      pulse_start(1'b0);
      capture(1'b0, 24, word, bad, ones);
      $display("t6: word=%06h bad=%0d", word, bad);
      chk("t6_word", word, 24'hFF8040);
`endif
      chk("t6_shape", bad, 0);
      rst_n_a = 1'b0;
      #1;
      chk("t6_abort_busy", busy_a, 0);
      tick();
      rst_n_a = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
